salsa_seq: RTL and testbench

SALSA_SEQ -- requirements
Module: salsa_seq

---
 rtl/salsa_seq.sv | 189 ++++++++++++++++++
 tb/tb_salsa_seq.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/salsa_seq.sv
// salsa_seq: sequencer wrapping an external two-cycle Salsa core.
// Feeds each job through DROUNDS core passes, then adds the original
// block lanewise and holds the result until it is taken.
// Build option: define SALSA_INTERLEAVE_EN for two contexts sharing the
// core on alternating phases; undefined gives a single context.
module salsa_seq #(
  parameter int unsigned DROUNDS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [511:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [511:0] core_xx,
  input  logic [511:0] core_out,
  output logic [511:0] out_data,
  output logic [9:0]   out_xaddr,
  output logic         out_slot,
  output logic         out_valid,
  input  logic         out_ready
);

`ifdef SALSA_INTERLEAVE_EN
  localparam int unsigned NCtx = 2;
`else
  localparam int unsigned NCtx = 1;
`endif

  // Pass counter value once the final core pass has been issued.
  localparam logic [1:0] LastPass = 2'(DROUNDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StSum, StHold} state_e;

  state_e       state_q [NCtx];
  state_e       state_d [NCtx];
  logic [1:0]   cnt_q   [NCtx];
  logic [1:0]   cnt_d   [NCtx];
  logic         sub_q   [NCtx];
  logic         sub_d   [NCtx];
  logic [511:0] b_q     [NCtx];
  logic [511:0] b_d     [NCtx];
  logic [511:0] res_q   [NCtx];
  logic [511:0] res_d   [NCtx];

  logic            alive_q;
  logic            lock_q;
  logic            lock_slot_q;
  logic [NCtx-1:0] can_acc;
  logic [NCtx-1:0] own;
  logic            found;
  logic            low_slot;

  // Sixteen independent 32-bit adds; no carry crosses a word boundary.
  function automatic logic [511:0] add_lanes(input logic [511:0] a, input logic [511:0] b);
    logic [511:0] s;
    s = '0;
    for (int k = 0; k < 16; k++) begin
      s[32*k +: 32] = a[32*k +: 32] + b[32*k +: 32];
    end
    return s;
  endfunction

`ifdef SALSA_INTERLEAVE_EN
  logic phase_q;
  // Free-running core phase; held one cycle after release so slot 0 owns the first ready cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
    end else if (alive_q) begin
      phase_q <= ~phase_q;
    end
  end

  // Each context may only start on its own core phase.
  always_comb begin
    own = '0;
    for (int c = 0; c < NCtx; c++) begin
      own[c] = (phase_q == 1'(c));
    end
  end
`else
  // Single context may start in any idle cycle.
  always_comb begin
    own = '1;
  end
`endif

  // Acceptance decoded from registered state only.
  always_comb begin
    can_acc = '0;
    for (int c = 0; c < NCtx; c++) begin
      can_acc[c] = alive_q && (state_q[c] == StIdle) && own[c];
    end
    in_ready = |can_acc;
  end

  // Result selection: lowest held slot, pinned while the consumer stalls.
  always_comb begin
    found    = 1'b0;
    low_slot = 1'b0;
    for (int c = NCtx - 1; c >= 0; c--) begin
      if (state_q[c] == StHold) begin
        found    = 1'b1;
        low_slot = 1'(c);
      end
    end
    out_valid = found;
    out_slot  = lock_q ? lock_slot_q : low_slot;
    out_data  = '0;
    for (int c = 0; c < NCtx; c++) begin
      if (found && (out_slot == 1'(c))) begin
        out_data = res_q[c];
      end
    end
    out_xaddr = out_data[9:0];
  end

  // Per-context FSM next state and core input mux.
  always_comb begin
    core_xx = '0;
    for (int c = 0; c < NCtx; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      sub_d[c]   = ~sub_q[c];
      b_d[c]     = b_q[c];
      res_d[c]   = res_q[c];
      unique case (state_q[c])
        StIdle: begin
          if (can_acc[c] && in_valid) begin
            state_d[c] = StRun;
            cnt_d[c]   = 2'd0;
            sub_d[c]   = 1'b0;
            b_d[c]     = in_data;
            core_xx    = in_data;
          end
        end
        StRun: begin
          // sub_q marks the cycles where core_out belongs to this context.
          if (sub_q[c]) begin
            if (cnt_q[c] != LastPass) begin
              core_xx  = core_out;
              cnt_d[c] = cnt_q[c] + 2'd1;
            end
          end else if (cnt_q[c] == LastPass) begin
            state_d[c] = StSum;
          end
        end
        StSum: begin
          res_d[c]   = add_lanes(core_out, b_q[c]);
          state_d[c] = StHold;
        end
        StHold: begin
          if (out_valid && out_ready && (out_slot == 1'(c))) begin
            state_d[c] = StIdle;
          end
        end
        default: state_d[c] = StIdle;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alive_q     <= 1'b0;
      lock_q      <= 1'b0;
      lock_slot_q <= 1'b0;
      for (int c = 0; c < NCtx; c++) begin
        state_q[c] <= StIdle;
        cnt_q[c]   <= 2'd0;
        sub_q[c]   <= 1'b0;
        b_q[c]     <= '0;
        res_q[c]   <= '0;
      end
    end else begin
      alive_q     <= 1'b1;
      lock_q      <= out_valid && !out_ready;
      lock_slot_q <= out_slot;
      for (int c = 0; c < NCtx; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        sub_q[c]   <= sub_d[c];
        b_q[c]     <= b_d[c];
        res_q[c]   <= res_d[c];
      end
    end
  end

endmodule

// File: tb/tb_salsa_seq.sv
// tb_salsa_seq: directed bench for salsa_seq with a behavioural two-cycle
// Salsa core (or an identity core for hand-computed adder vectors).
module tb_salsa_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [511:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] core_xx;
  logic [511:0] core_out;
  logic [511:0] out_data;
  logic [9:0]   out_xaddr;
  logic         out_slot;
  logic         out_valid;
  logic         out_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  salsa_seq #(.DROUNDS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .core_xx   (core_xx),
    .core_out  (core_out),
    .out_data  (out_data),
    .out_xaddr (out_xaddr),
    .out_slot  (out_slot),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Quarter-round index table: four column rounds then four row rounds.
  localparam int QA [8] = '{0, 5, 10, 15, 0, 5, 10, 15};
  localparam int QB [8] = '{4, 9, 14, 3, 1, 6, 11, 12};
  localparam int QC [8] = '{8, 13, 2, 7, 2, 7, 8, 13};
  localparam int QD [8] = '{12, 1, 6, 11, 3, 4, 9, 14};

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [511:0] dround(input logic [511:0] xin);
    logic [31:0]  x [16];
    logic [511:0] r;
    for (int k = 0; k < 16; k++) x[k] = xin[32*k +: 32];
    for (int i = 0; i < 8; i++) begin
      x[QB[i]] ^= rotl(x[QA[i]] + x[QD[i]], 7);
      x[QC[i]] ^= rotl(x[QB[i]] + x[QA[i]], 9);
      x[QD[i]] ^= rotl(x[QC[i]] + x[QB[i]], 13);
      x[QA[i]] ^= rotl(x[QD[i]] + x[QC[i]], 18);
    end
    r = '0;
    for (int k = 0; k < 16; k++) r[32*k +: 32] = x[k];
    return r;
  endfunction

  // Full Salsa20/8 reference: four double rounds plus the feed-forward add.
  function automatic logic [511:0] salsa_ref(input logic [511:0] b);
    logic [511:0] x;
    logic [511:0] r;
    x = b;
    for (int i = 0; i < 4; i++) x = dround(x);
    r = '0;
    for (int k = 0; k < 16; k++) r[32*k +: 32] = x[32*k +: 32] + b[32*k +: 32];
    return r;
  endfunction

  // Byte string (first byte leftmost) to bus with byte i at bits [8i+7:8i].
  function automatic logic [511:0] from_bytes(input logic [511:0] s);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) r[8*i +: 8] = s[511 - 8*i -: 8];
    return r;
  endfunction

  // External core model: result appears two edges after core_xx.
  logic         core_ident = 1'b0;
  logic [511:0] pipe1 = '0;
  logic [511:0] pipe2 = '0;
  always @(posedge clk) begin
    pipe1 <= core_ident ? core_xx : dround(core_xx);
    pipe2 <= pipe1;
  end
  assign core_out = pipe2;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // Starts and ends at a negedge; waits (bounded) for in_ready.
  task automatic wait_ready(output logic ok);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    ok = in_ready;
    if (!ok) chkb("accept_wait", in_ready, 1'b1);
  endtask

  // One job accepted at cycle 0; result must show at cycle 9 exactly.
  task automatic run_job(input logic [511:0] b, input logic [511:0] exp, input logic after);
    logic ok;
    logic early;
    early = 1'b0;
    wait_ready(ok);
    if (!ok) return;
    in_data  = b;
    in_valid = 1'b1;
    #1;
    chk("core_xx_at_accept", core_xx, b);
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
      if (n < 9) early |= out_valid;
    end
    chkb("no_early_valid", early, 1'b0);
    chkb("valid_at_cycle9", out_valid, 1'b1);
    chk("out_data", out_data, exp);
    chk("out_xaddr", {502'b0, out_xaddr}, {502'b0, exp[9:0]});
`ifndef SALSA_INTERLEAVE_EN
    chkb("out_slot", out_slot, 1'b0);
`endif
    if (after) begin
      @(negedge clk);
      chkb("valid_clears", out_valid, 1'b0);
`ifndef SALSA_INTERLEAVE_EN
      chkb("ready_after_take", in_ready, 1'b1);
`endif
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic         ident;
    logic [511:0] b;
    logic [511:0] exp;
  } vec_t;

  vec_t         vt [6];
  logic [511:0] rfc_in;
  logic [511:0] rfc_out;
  logic [511:0] s_tmp;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic ok;
    logic err_v, err_d, err_r, seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    s_tmp   = 512'h7e879a214f3ec9867ca940e641718f26baee555b8c61c1b50df846116dcd3b1dee24f319df9b3d8514121e4b5ac5aa3276021d2909c74829edebc68db8b8c25e;
    rfc_in  = from_bytes(s_tmp);
    s_tmp   = 512'ha41f859c6608cc993b81cacb020cef05044b2181a2fd337dfd7b1c6396682f29b4393168e3c9e6bcfe6bc5b7a06d96bae424cc102c91745c24ad673dc7618f81;
    rfc_out = from_bytes(s_tmp);

    vt[0].ident = 1'b0; vt[0].b = '0;                         vt[0].exp = '0;
    vt[1].ident = 1'b1; vt[1].b = {448'h0, 32'h1, 32'hffffffff};  vt[1].exp = {448'h0, 32'h2, 32'hfffffffe};
    vt[2].ident = 1'b1; vt[2].b = {16{32'h80000000}};          vt[2].exp = '0;
    vt[3].ident = 1'b1; vt[3].b = {16{32'h12345678}};          vt[3].exp = {16{32'h2468acf0}};
    vt[4].ident = 1'b1; vt[4].b = {480'h0, 32'h80000001};      vt[4].exp = {480'h0, 32'h2};
    vt[5].ident = 1'b0; vt[5].b = rfc_in;                      vt[5].exp = rfc_out;

    // Reset values.
    repeat (3) @(negedge clk);
    chkb("rst_in_ready", in_ready, 1'b0);
    chkb("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_xaddr", {502'b0, out_xaddr}, '0);
    chkb("rst_out_slot", out_slot, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chkb("ready_after_release", in_ready, 1'b1);
    chk("idle_core_xx", core_xx, '0);

    for (int i = 0; i < 6; i++) begin
      core_ident = vt[i].ident;
      run_job(vt[i].b, vt[i].exp, 1'b1);
    end

    // Consumer stall: result parked and stable for 20 cycles.
    core_ident = 1'b0;
    out_ready  = 1'b0;
    run_job(rfc_in, rfc_out, 1'b0);
    err_v = 1'b0; err_d = 1'b0; err_r = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      err_v |= (out_valid !== 1'b1);
      err_d |= (out_data !== rfc_out);
`ifndef SALSA_INTERLEAVE_EN
      err_r |= (in_ready !== 1'b0);
`endif
    end
    chkb("stall_valid_held", err_v, 1'b0);
    chkb("stall_data_stable", err_d, 1'b0);
    chkb("stall_ready_low", err_r, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    chkb("stall_take_clears", out_valid, 1'b0);
`ifndef SALSA_INTERLEAVE_EN
    chkb("stall_ready_after", in_ready, 1'b1);
`endif

    // Reset at cycle 4 of a job discards it.
    wait_ready(ok);
    if (ok) begin
      in_data  = {16{32'hdeadbeef}};
      in_valid = 1'b1;
      for (int n = 1; n <= 4; n++) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      chkb("midrst_in_ready", in_ready, 1'b0);
      chkb("midrst_out_valid", out_valid, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chkb("midrst_ready_rise", in_ready, 1'b1);
      seen = 1'b0;
      for (int n = 0; n < 15; n++) begin
        @(negedge clk);
        seen |= out_valid;
      end
      chkb("midrst_no_output", seen, 1'b0);
      run_job(rfc_in, rfc_out, 1'b1);
    end

`ifdef SALSA_INTERLEAVE_EN
    // Two back-to-back jobs on the two contexts.
    begin
      logic [511:0] ja, jb;
      int           ev_n;
      int           ev_cyc [2];
      logic         ev_slot [2];
      logic [511:0] ev_data [2];
      ja = rfc_in;
      jb = {16{32'h01020304}};
      ev_n = 0;
      do_reset();
      chkb("il_ready0", in_ready, 1'b1);
      in_data  = ja;
      in_valid = 1'b1;
      @(negedge clk);
      chkb("il_ready1", in_ready, 1'b1);
      in_data = jb;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
      for (int n = 2; n < 30; n++) begin
        if (out_valid && ev_n < 2) begin
          ev_cyc[ev_n]  = n;
          ev_slot[ev_n] = out_slot;
          ev_data[ev_n] = out_data;
          ev_n++;
        end
        @(negedge clk);
      end
      chk("il_result_count", 512'(ev_n), 512'd2);
      if (ev_n == 2) begin
        chkb("il_first_slot", ev_slot[0], 1'b0);
        chkb("il_second_slot", ev_slot[1], 1'b1);
        chk("il_first_data", ev_data[0], salsa_ref(ja));
        chk("il_second_data", ev_data[1], salsa_ref(jb));
        chk("il_first_cycle", 512'(ev_cyc[0]), 512'd9);
        chk("il_second_cycle", 512'(ev_cyc[1]), 512'd10);
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
